// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//
// Multi-round controller for the reaction-typing game. Each game has ROUNDS
// rounds. A round is a random pre-delay, then an armed window in which the
// player must type the target letter, then a held result/miss display.
//
// Ports
//   clk          system clock (100 MHz)
//   rst_n        asynchronous active-low reset
//   letter[4:0]  current keyboard-wrapper code (level; RELEASE_CODE = released)
//   rand_val[4:0] free-running LFSR value, sampled at game start, at round
//                restart and at arming
//   ms_tick      one-clk pulse per millisecond
//   goal[4:0]    target letter 0..25
//   timer_ctrl   stopwatch control, bit1 = enable, bit0 = reset
//   disp_sel     0 result/best, 1 goal, 2 loss, 3 idle
//   react_ms     last hit reaction time (ms)
//   best_ms      best hit time this game, 9999 = none
//   hits         hits this game
//   round        completed rounds this game
//   game_over    high while the game is finished
//
// The port carrying the LFSR value is rand_val because "rand" is a reserved
// word in SystemVerilog.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for any key to start a game
// WAIT   | random pre-delay counting down; a key here is a false start
// ARMED  | goal shown, reaction counter counting up until key or timeout
// RESULT | hit shown for HOLD_MS
// MISS   | false start / wrong key / timeout shown for HOLD_MS
// DONE   | game finished, any key starts a new game
// -----------------------------------------------------------------------------
module round_sequencer #(
  parameter int ROUNDS        = 5,
  parameter int TIMEOUT_MS    = 2000,
  parameter int HOLD_MS       = 1000,
  parameter int DELAY_MIN_MS  = 500,
  parameter int DELAY_STEP_MS = 32,
  parameter int RELEASE_CODE  = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  letter,
  input  logic [4:0]  rand_val,
  input  logic        ms_tick,
  output logic [4:0]  goal,
  output logic [1:0]  timer_ctrl,
  output logic [1:0]  disp_sel,
  output logic [13:0] react_ms,
  output logic [13:0] best_ms,
  output logic [3:0]  hits,
  output logic [3:0]  round,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ARMED  = 3'd2,
    S_RESULT = 3'd3,
    S_MISS   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [4:0]  REL_C     = 5'(RELEASE_CODE);
  localparam logic [13:0] CNT_MAX   = 14'd9999;
  localparam logic [13:0] HOLD_C    = 14'(HOLD_MS);
  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT_MS);
  localparam logic [3:0]  ROUNDS_C  = 4'(ROUNDS);

  localparam logic [1:0] TC_RESET = 2'b01;
  localparam logic [1:0] TC_RUN   = 2'b10;
  localparam logic [1:0] TC_HOLD  = 2'b00;

  localparam logic [1:0] DS_RESULT = 2'd0;
  localparam logic [1:0] DS_GOAL   = 2'd1;
  localparam logic [1:0] DS_LOSS   = 2'd2;
  localparam logic [1:0] DS_IDLE   = 2'd3;

  state_t      state_q, state_d;
  logic [4:0]  letter_q;
  logic [13:0] cnt_q, cnt_d;
  logic [4:0]  goal_d;
  logic [1:0]  tc_d;
  logic [1:0]  disp_d;
  logic [13:0] react_d;
  logic [13:0] best_d;
  logic [3:0]  hits_d;
  logic [3:0]  round_d;
  logic        over_d;

  logic        kev;
  logic [3:0]  round_inc;
  logic        timeout_hit;
  logic [13:0] predelay;
  logic [4:0]  goal_map;
  logic [31:0] predelay_full;

  // A new key event is any change of code that is not a release. letter_q
  // resets to the release code so a key held through reset counts once.
  assign kev = (letter != letter_q) && (letter != REL_C);

  assign predelay_full = 32'(DELAY_MIN_MS) + 32'(rand_val) * 32'(DELAY_STEP_MS);
  assign predelay      = predelay_full[13:0];

  // Fold 26..31 onto 20..25 so every LFSR value maps to a letter.
  assign goal_map = (rand_val > 5'd25) ? (rand_val - 5'd6) : rand_val;

  assign round_inc = round + 4'd1;

  // Timeout is decided on the tick that would bring the count to TIMEOUT_MS,
  // so a key arriving with that same tick still wins.
  assign timeout_hit = ms_tick && ((32'(cnt_q) + 32'd1) >= TIMEOUT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      letter_q   <= REL_C;
      cnt_q      <= '0;
      goal       <= '0;
      timer_ctrl <= TC_RESET;
      disp_sel   <= DS_IDLE;
      react_ms   <= '0;
      best_ms    <= CNT_MAX;
      hits       <= '0;
      round      <= '0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      letter_q   <= letter;
      cnt_q      <= cnt_d;
      goal       <= goal_d;
      timer_ctrl <= tc_d;
      disp_sel   <= disp_d;
      react_ms   <= react_d;
      best_ms    <= best_d;
      hits       <= hits_d;
      round      <= round_d;
      game_over  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    goal_d  = goal;
    react_d = react_ms;
    best_d  = best_ms;
    hits_d  = hits;
    round_d = round;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (kev) begin
          hits_d  = '0;
          round_d = '0;
          react_d = '0;
          best_d  = CNT_MAX;
          cnt_d   = predelay;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (kev) begin
          cnt_d   = HOLD_C;
          state_d = S_MISS;
        end else if (ms_tick) begin
          // <=1 rather than ==1 so a zero-length pre-delay still arms.
          if (cnt_q <= 14'd1) begin
            goal_d  = goal_map;
            cnt_d   = '0;
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q - 14'd1;
          end
        end
      end

      S_ARMED: begin
        if (kev) begin
          cnt_d = HOLD_C;
          if (letter == goal) begin
            react_d = cnt_q;
            if (hits != ROUNDS_C) hits_d = hits + 4'd1;
            if (cnt_q < best_ms) best_d = cnt_q;
            state_d = S_RESULT;
          end else begin
            state_d = S_MISS;
          end
        end else if (timeout_hit) begin
          cnt_d   = HOLD_C;
          state_d = S_MISS;
        end else if (ms_tick && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      S_RESULT, S_MISS: begin
        if (ms_tick) begin
          if (cnt_q <= 14'd1) begin
            round_d = round_inc;
            if (round_inc >= ROUNDS_C) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d   = predelay;
              state_d = S_WAIT;
            end
          end else begin
            cnt_d = cnt_q - 14'd1;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the next state so they change one clk after
  // the deciding input.
  always_comb begin
    tc_d   = TC_RESET;
    disp_d = DS_IDLE;
    over_d = 1'b0;

    unique case (state_d)
      S_IDLE, S_WAIT: begin
        tc_d   = TC_RESET;
        disp_d = DS_IDLE;
      end
      S_ARMED: begin
        // Hold the stopwatch in reset on the entry cycle so it starts at zero.
        tc_d   = (state_q == S_ARMED) ? TC_RUN : TC_RESET;
        disp_d = DS_GOAL;
      end
      S_RESULT: begin
        tc_d   = TC_HOLD;
        disp_d = DS_RESULT;
      end
      S_MISS: begin
        tc_d   = TC_HOLD;
        disp_d = DS_LOSS;
      end
      S_DONE: begin
        tc_d   = TC_HOLD;
        disp_d = DS_RESULT;
        over_d = 1'b1;
      end
      default: begin
        tc_d   = TC_RESET;
        disp_d = DS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
//
// Bench for round_sequencer with small game parameters. A game-level model
// (elapsed-tick counters per phase) predicts every output each cycle; a set
// of hand-computed literal checks pins the model on directed scenarios, then
// randomized keys/ticks/LFSR values run against the model.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

  localparam int ROUNDS = 2;
  localparam int TMO    = 50;
  localparam int HOLD   = 10;
  localparam int DMIN   = 20;
  localparam int DSTEP  = 1;
  localparam int REL    = 21;

  localparam int PH_IDLE   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_ARMED  = 2;
  localparam int PH_RESULT = 3;
  localparam int PH_MISS   = 4;
  localparam int PH_DONE   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  letter = 5'd21;
  logic [4:0]  rand_val = 5'd0;
  logic        ms_tick = 1'b0;
  logic [4:0]  goal;
  logic [1:0]  timer_ctrl;
  logic [1:0]  disp_sel;
  logic [13:0] react_ms;
  logic [13:0] best_ms;
  logic [3:0]  hits;
  logic [3:0]  round;
  logic        game_over;

  always #5 clk = ~clk;

  round_sequencer #(
    .ROUNDS(ROUNDS), .TIMEOUT_MS(TMO), .HOLD_MS(HOLD),
    .DELAY_MIN_MS(DMIN), .DELAY_STEP_MS(DSTEP), .RELEASE_CODE(REL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .letter(letter), .rand_val(rand_val),
    .ms_tick(ms_tick), .goal(goal), .timer_ctrl(timer_ctrl),
    .disp_sel(disp_sel), .react_ms(react_ms), .best_ms(best_ms),
    .hits(hits), .round(round), .game_over(game_over)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  int m_phase, m_elapsed, m_target, m_prev;
  int m_goal, m_react, m_best, m_hits, m_round;
  bit m_fresh;

  function automatic int gmap(input int r);
    return (r > 25) ? r - 6 : r;
  endfunction

  function automatic int pdelay(input int r);
    return DMIN + r * DSTEP;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_elapsed = 0; m_target = 0; m_prev = REL;
    m_goal = 0; m_react = 0; m_best = 9999; m_hits = 0; m_round = 0;
    m_fresh = 1'b0;
  endtask

  task automatic start_wait(input int r);
    m_phase = PH_WAIT; m_elapsed = 0; m_target = pdelay(r);
  endtask

  task automatic model_step();
    int l, r;
    bit kev;
    l = int'(letter);
    r = int'(rand_val);
    kev = (l != m_prev) && (l != REL);
    m_prev = l;
    m_fresh = 1'b0;
    case (m_phase)
      PH_IDLE, PH_DONE: begin
        if (kev) begin
          m_hits = 0; m_round = 0; m_react = 0; m_best = 9999;
          start_wait(r);
        end
      end
      PH_WAIT: begin
        if (kev) begin
          m_phase = PH_MISS; m_elapsed = 0;
        end else if (ms_tick) begin
          m_elapsed++;
          if (m_elapsed >= m_target) begin
            m_goal = gmap(r); m_phase = PH_ARMED; m_elapsed = 0; m_fresh = 1'b1;
          end
        end
      end
      PH_ARMED: begin
        if (kev) begin
          if (l == m_goal) begin
            m_react = m_elapsed;
            m_hits++;
            if (m_elapsed < m_best) m_best = m_elapsed;
            m_phase = PH_RESULT;
          end else begin
            m_phase = PH_MISS;
          end
          m_elapsed = 0;
        end else if (ms_tick) begin
          if (m_elapsed + 1 >= TMO) begin
            m_phase = PH_MISS; m_elapsed = 0;
          end else if (m_elapsed < 9999) begin
            m_elapsed++;
          end
        end
      end
      default: begin  // RESULT / MISS
        if (ms_tick) begin
          m_elapsed++;
          if (m_elapsed >= HOLD) begin
            m_round++;
            if (m_round == ROUNDS) begin
              m_phase = PH_DONE; m_elapsed = 0;
            end else begin
              start_wait(r);
            end
          end
        end
      end
    endcase
  endtask

  function automatic int m_disp();
    case (m_phase)
      PH_ARMED:  return 1;
      PH_RESULT: return 0;
      PH_MISS:   return 2;
      PH_DONE:   return 0;
      default:   return 3;
    endcase
  endfunction

  function automatic int m_tc();
    case (m_phase)
      PH_IDLE, PH_WAIT: return 1;
      PH_ARMED:         return m_fresh ? 1 : 2;
      default:          return 0;
    endcase
  endfunction

  // Single compare process: model holds post-edge values before each posedge.
  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      chk("goal",       int'(goal),       m_goal);
      chk("timer_ctrl", int'(timer_ctrl), m_tc());
      chk("disp_sel",   int'(disp_sel),   m_disp());
      chk("react_ms",   int'(react_ms),   m_react);
      chk("best_ms",    int'(best_ms),    m_best);
      chk("hits",       int'(hits),       m_hits);
      chk("round",      int'(round),      m_round);
      chk("game_over",  int'(game_over),  (m_phase == PH_DONE) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic cyc(input bit t);
    ms_tick = t;
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    end
  endtask

  task automatic press(input int l, input bit t);
    letter = 5'(l);
    cyc(t);
  endtask

  task automatic release_key();
    letter = 5'(REL);
    cyc(1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_goal"},  int'(goal), 0);
    chk({tag, "_tc"},    int'(timer_ctrl), 1);
    chk({tag, "_disp"},  int'(disp_sel), 3);
    chk({tag, "_react"}, int'(react_ms), 0);
    chk({tag, "_best"},  int'(best_ms), 9999);
    chk({tag, "_hits"},  int'(hits), 0);
    chk({tag, "_round"}, int'(round), 0);
    chk({tag, "_over"},  int'(game_over), 0);
  endtask

  initial begin
    int r;
    bit t;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(0); cyc(0); cyc(0);

    // Start: rand=3 gives a 23-tick pre-delay.
    rand_val = 5'd3;
    press(7, 0);
    chk("start_disp", int'(disp_sel), 3);
    release_key();
    rand_val = 5'd30;
    ticks(22);
    chk("wait22_disp", int'(disp_sel), 3);
    cyc(1);
    chk("armed_disp", int'(disp_sel), 1);
    chk("armed_tc0",  int'(timer_ctrl), 1);
    chk("armed_goal", int'(goal), 24);
    cyc(0);
    chk("armed_tc1",  int'(timer_ctrl), 2);
    cyc(0); cyc(0);

    // Hit after 12 ticks.
    ticks(12);
    press(24, 0);
    chk("hit_react", int'(react_ms), 12);
    chk("hit_best",  int'(best_ms), 12);
    chk("hit_hits",  int'(hits), 1);
    chk("hit_disp",  int'(disp_sel), 0);
    chk("hit_tc",    int'(timer_ctrl), 0);
    release_key();
    rand_val = 5'd0;
    ticks(9);
    chk("hold9_round", int'(round), 0);
    cyc(1);
    chk("hold_round", int'(round), 1);
    chk("hold_disp",  int'(disp_sel), 3);
    cyc(0); cyc(0); cyc(0);

    // Wrong key in round 2 ends the game.
    rand_val = 5'd5;
    ticks(19);
    cyc(1);
    chk("r2_goal", int'(goal), 5);
    cyc(0); cyc(0); cyc(0);
    ticks(3);
    press(9, 0);
    chk("wrong_disp",  int'(disp_sel), 2);
    chk("wrong_react", int'(react_ms), 12);
    release_key();
    ticks(10);
    chk("done_over",  int'(game_over), 1);
    chk("done_hits",  int'(hits), 1);
    chk("done_round", int'(round), 2);

    // Restart from DONE.
    rand_val = 5'd0;
    press(3, 0);
    chk("restart_hits",  int'(hits), 0);
    chk("restart_round", int'(round), 0);
    chk("restart_best",  int'(best_ms), 9999);
    chk("restart_over",  int'(game_over), 0);
    release_key();

    // False start: goal keeps its old value.
    rand_val = 5'd10;
    ticks(5);
    press(8, 0);
    chk("false_disp", int'(disp_sel), 2);
    chk("false_goal", int'(goal), 5);
    release_key();
    rand_val = 5'd0;
    ticks(10);
    chk("false_round", int'(round), 1);

    // Timeout on the 50th armed tick.
    cyc(0); cyc(0); cyc(0);
    rand_val = 5'd17;
    ticks(19);
    cyc(1);
    cyc(0); cyc(0); cyc(0);
    ticks(49);
    chk("tmo49_disp", int'(disp_sel), 1);
    cyc(1);
    chk("tmo_disp",  int'(disp_sel), 2);
    chk("tmo_react", int'(react_ms), 0);
    cyc(0); cyc(0); cyc(0);
    ticks(10);
    chk("tmo_over", int'(game_over), 1);
    chk("tmo_hits", int'(hits), 0);

    // Tie: key together with the 50th tick records 49.
    rand_val = 5'd0;
    press(4, 0);
    release_key();
    rand_val = 5'd12;
    ticks(19);
    cyc(1);
    cyc(0); cyc(0); cyc(0);
    ticks(49);
    press(12, 1);
    chk("tie_react", int'(react_ms), 49);
    chk("tie_hits",  int'(hits), 1);
    chk("tie_best",  int'(best_ms), 49);
    release_key();
    rand_val = 5'd0;
    ticks(10);
    ticks(19);
    cyc(1);
    cyc(0);
    ticks(5);
    chk("pre_rst_disp", int'(disp_sel), 1);

    // Asynchronous reset mid-ARMED.
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    @(negedge clk);
    letter = 5'(REL);
    rst_n = 1'b1;
    cyc(0); cyc(0);

    // Randomized play against the model.
    for (int i = 0; i < 20000; i++) begin
      rand_val = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 99);
      if (r < 1) letter = 5'(REL);
      else if (r < 2) letter = 5'(m_goal);
      else if (r < 3) letter = 5'($urandom_range(0, 25));
      t = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4999) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 3) == 0) rst_n = 1'b1;
      cyc(t);
    end

    rst_n = 1'b1;
    cyc(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Multi-round game controller for the reaction-typing game on the Basys 3. It consumes key events from the keyboard wrapper, a random value from the LFSR and a 1 ms tick. It drives the stopwatch timer's control pair, the target letter and the display-mux select. Over a fixed number of rounds it produces the last reaction time, the best reaction time and the hit count, replacing the ad-hoc top-level game FSM.

## Interface
- ROUNDS, 5: rounds per game (1..15).
- TIMEOUT_MS, 2000: ms allowed after arming before the round is a miss.
- HOLD_MS, 1000: ms the result/miss display is held.
- DELAY_MIN_MS, 500: minimum random pre-delay.
- DELAY_STEP_MS, 32: pre-delay added per unit of `rand`.
- RELEASE_CODE, 21: keyboard-wrapper code meaning "key released".
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- letter  in  5  current code from the keyboard wrapper; level output, changes once per key action.
- rand  in  5  free-running LFSR value; sampled only at the points defined below.
- ms_tick  in  1  one-`clk` pulse every millisecond.
- goal  out  5  target letter, 0..25.
- timer_ctrl  out  2  to the stopwatch: bit1 = enable, bit0 = reset.
- disp_sel  out  2  0 = result/best, 1 = goal, 2 = loss, 3 = idle.
- react_ms  out  14  last hit reaction time, binary ms.
- best_ms  out  14  best hit time this game; 9999 = none.
- hits  out  4  hits this game.
- round  out  4  completed rounds this game.
- game_over  out  1  high in DONE.

## Operation
- Key event: `letter_q` is a register loaded from `letter` every cycle; it resets to RELEASE_CODE.
  - kev = (letter != letter_q) && (letter != RELEASE_CODE).
  - A release followed by the same key re-press produces a new event.
  - A key held through reset release produces one event.
- Counter `cnt` is 14-bit and advances only on cycles where `ms_tick` is high.
- Goal mapping is goal = (rand > 25) ? rand - 6 : rand.
- States, with outputs:
  - IDLE: timer_ctrl=01, disp_sel=3.
    - On kev, clear hits, round and react_ms; set best_ms=9999.
    - Load cnt = DELAY_MIN_MS + rand*DELAY_STEP_MS and go to WAIT.
  - WAIT: timer_ctrl=01, disp_sel=3. cnt counts down on ms_tick.
    - kev here is a false start: go to MISS.
    - When cnt==0, latch goal from rand, clear cnt and go to ARMED.
  - ARMED: timer_ctrl=10, disp_sel=1. cnt counts up on ms_tick and saturates at 9999.
    - kev with letter==goal is a hit:
      - react_ms=cnt and hits+1.
      - best_ms=min(best_ms, cnt).
      - Go to RESULT.
    - kev with letter!=goal: go to MISS; react_ms is unchanged.
    - cnt==TIMEOUT_MS with no kev: go to MISS.
  - RESULT: timer_ctrl=00, disp_sel=0. MISS: timer_ctrl=00, disp_sel=2.
    - In both states cnt counts HOLD_MS ticks and kev is ignored.
    - At the end of the hold, round+1.
    - If the new round==ROUNDS, go to DONE. Otherwise load the pre-delay from rand as in IDLE and go to WAIT.
  - DONE: timer_ctrl=00, disp_sel=0, game_over=1.
    - kev restarts the game with the same actions as IDLE on kev.
- Width rules:
  - hits and round never exceed ROUNDS.
  - The best_ms compare is unsigned 14-bit.
  - A hit at cnt=9999 leaves best_ms at 9999.

## Timing
- Reset values: state IDLE, goal=0, timer_ctrl=01, disp_sel=3, react_ms=0, best_ms=9999, hits=0, round=0, game_over=0.
- All outputs are registered and change one `clk` after the cycle in which `letter` changed or in which the deciding `ms_tick` was high.
- Simultaneous events:
  - kev and ms_tick in the same ARMED cycle: the hit records cnt before increment.
  - kev and timeout in the same cycle: kev wins.
- Pre-delay reaching 0 and kev in the same cycle: kev wins, giving a false start (MISS).
- The ARMED entry cycle outputs timer_ctrl=01 for exactly one cycle, then 10, so the stopwatch restarts from zero.
- A reset assertion mid-round forces all reset values immediately, asynchronously.

## Test plan
Directed tests use ROUNDS=2, TIMEOUT_MS=50, HOLD_MS=10, DELAY_MIN_MS=20, DELAY_STEP_MS=1, with ms_tick every 4 clk.
- Start:
  - Stimulus: rand=3 and letter 21→7 in IDLE.
  - Required: WAIT is entered; after 23 ticks the block is ARMED with disp_sel=1; timer_ctrl shows one cycle of 01, then 10.
- Hit:
  - Stimulus: rand=30 at arming, so goal=24; letter 21→24 after 12 ticks.
  - Required: react_ms=12, best_ms=12, hits=1, disp_sel=0; after 10 ticks round=1 and WAIT is re-entered.
- Wrong key and timeout:
  - Stimulus: a wrong letter in ARMED; in the next round, no key.
  - Required: wrong letter gives disp_sel=2 with react_ms unchanged; no key gives MISS at tick 50; after round 2, game_over=1 and hits=1.
- False start:
  - Stimulus: kev during WAIT.
  - Required: MISS; goal is not relatched.
- Tie:
  - Stimulus: kev coinciding with the 50th tick and with ms_tick.
  - Required: hit recorded with react_ms=49.
- Reset mid-ARMED and restart:
  - Stimulus: rst_n low mid-ARMED; separately, kev in DONE.
  - Required: reset gives all reset values at once; kev in DONE clears hits/round and sets best_ms=9999.
